// File: rtl/des_ctrl.sv
// Round-robin front end that time-shares one combinational DES core
// between two requesters and returns each result with its owner id.
module des_ctrl #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [63:0] REQ0_KEY,
    input  logic [63:0] REQ0_DATA,
    input  logic        REQ0_DECRYPT,
    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [63:0] REQ1_KEY,
    input  logic [63:0] REQ1_DATA,
    input  logic        REQ1_DECRYPT,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [63:0] RSP_DATA,
    output logic        RSP_ID,
    output logic [63:0] CORE_KEY,
    output logic [63:0] CORE_DATA,
    output logic        CORE_DECRYPT,
    input  logic [63:0] CORE_RESULT,
    output logic        BUSY
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [63:0]      key_q, key_d;
    logic [63:0]      data_q, data_d;
    logic             dec_q, dec_d;
    logic [63:0]      rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             idle;
    logic             gnt0, gnt1;

    assign idle = RST_N && (state_q == S_IDLE);

    // last_q names the requester served most recently; the other wins a tie
    assign gnt0 = idle && REQ0_VALID && (!REQ1_VALID || last_q);
    assign gnt1 = idle && REQ1_VALID && (!REQ0_VALID || !last_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        key_d       = key_q;
        data_d      = data_q;
        dec_d       = dec_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    key_d    = gnt1 ? REQ1_KEY : REQ0_KEY;
                    data_d   = gnt1 ? REQ1_DATA : REQ0_DATA;
                    dec_d    = gnt1 ? REQ1_DECRYPT : REQ0_DECRYPT;
                    rsp_id_d = gnt1;
                    last_d   = gnt1;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = CORE_RESULT;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            key_q       <= '0;
            data_q      <= '0;
            dec_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            key_q       <= key_d;
            data_q      <= data_d;
            dec_q       <= dec_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign REQ0_READY   = gnt0;
    assign REQ1_READY   = gnt1;
    assign RSP_VALID    = rsp_valid_q;
    assign RSP_DATA     = rsp_data_q;
    assign RSP_ID       = rsp_id_q;
    assign CORE_KEY     = key_q;
    assign CORE_DATA    = data_q;
    assign CORE_DECRYPT = dec_q;
    assign BUSY         = (state_q != S_IDLE);

endmodule

// File: doc/des_ctrl.md
DES_CTRL -- requirements
Module: des_ctrl

Interface
REQ-001 Parameter: LATENCY, default 2, cycles CORE_RESULT needs to settle after core inputs change (legal 1..15).
REQ-002 Parameter: CNT_W, default 4, width of the settle counter.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 REQ0_VALID  input  1  requester 0 has a job.
REQ-006 REQ0_READY  output  1  requester 0 job accepted this cycle.
REQ-007 REQ0_KEY  input  64  requester 0 key.
REQ-008 REQ0_DATA  input  64  requester 0 plaintext or ciphertext.
REQ-009 REQ0_DECRYPT  input  1  1 = decrypt, 0 = encrypt.
REQ-010 REQ1_VALID / REQ1_READY / REQ1_KEY / REQ1_DATA / REQ1_DECRYPT  same widths and meanings as REQ-005..009, for requester 1.
REQ-011 RSP_VALID  output  1  result available.
REQ-012 RSP_READY  input  1  consumer accepts result.
REQ-013 RSP_DATA  output  64  result word.
REQ-014 RSP_ID  output  1  requester index owning RSP_DATA.
REQ-015 CORE_KEY  output  64  key driven to shared DES cores.
REQ-016 CORE_DATA  output  64  data driven to shared DES cores.
REQ-017 CORE_DECRYPT  output  1  selects decrypt core result.
REQ-018 CORE_RESULT  input  64  muxed combinational core output.
REQ-019 BUSY  output  1  high in every state except IDLE.

Function
REQ-020 FSM states IDLE, RUN, DONE; one-hot or binary at implementer's choice.
REQ-021 IDLE: when any REQx_VALID is high, grant one requester, pulse its REQx_READY for exactly one cycle, register KEY/DATA/DECRYPT into CORE_* and the requester index, load counter with LATENCY-1, go to RUN.
REQ-022 REQx_READY is combinational from state IDLE plus grant; never high outside IDLE; never both high.
REQ-023 Arbitration round-robin: with both valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-024 With only one valid, grant it regardless of last grant; last-grant pointer updates only on a grant.
REQ-025 RUN: CORE_* held constant; counter decrements each cycle; at counter = 0, capture CORE_RESULT into RSP_DATA, set RSP_VALID, go to DONE.
REQ-026 Latency: REQx_VALID&READY in cycle N -> RSP_VALID high in cycle N+LATENCY+1.
REQ-027 DONE: RSP_VALID, RSP_DATA, RSP_ID held stable until RSP_VALID&RSP_READY; on that edge clear RSP_VALID, go to IDLE.
REQ-028 No new job is accepted in the same cycle as a response handshake; earliest next grant is the following cycle.
REQ-029 RSP_READY asserted before RSP_VALID has no effect; requester valid changes during RUN/DONE are ignored.
REQ-030 Result word is bit-exact CORE_RESULT sampled on the capture edge; no transformation.

Reset
REQ-031 While RST_N low: state IDLE, REQ0_READY/REQ1_READY/RSP_VALID/BUSY = 0, RSP_DATA/CORE_KEY/CORE_DATA = 0, CORE_DECRYPT = 0, RSP_ID = 0, counter = 0, last-grant pointer = requester 1 (so 0 wins first).
REQ-032 Reset asserted mid-RUN or mid-DONE aborts the job immediately; no response is produced after release.
REQ-033 First grant possible on the first rising edge after RST_N deasserts.

Verification
REQ-034 Single encrypt, LATENCY=2: REQ0 key 8FFB3DD99EEA2CC8, data F7B3D591E6A2C480, DECRYPT=0, core = team encrypt/decrypt pair -> RSP_VALID 3 cycles after accept, RSP_DATA A02D50F02AC817A1, RSP_ID 0.
REQ-035 Round trip: REQ1 DECRYPT=1, key 8FFB3DD99EEA2CC8, data A02D50F02AC817A1 -> RSP_DATA F7B3D591E6A2C480, RSP_ID 1.
REQ-036 Contention: both valid continuously for 4 jobs from reset -> grant order 0,1,0,1; RSP_ID sequence matches.
REQ-037 Backpressure: RSP_READY low 5 cycles in DONE -> RSP_VALID/RSP_DATA stable, no READY pulses, BUSY high; accept occurs cycle after handshake.
REQ-038 Reset mid-RUN: RST_N low one cycle during RUN -> all outputs per REQ-031 asynchronously, no RSP_VALID afterwards until a new grant.
REQ-039 LATENCY=1 build: accept in cycle N -> RSP_VALID in cycle N+2.
